// File: rtl/inst_loader.sv
// inst_loader: packs decoded instruction fields into 16-bit words
// {addr_mode, opcode, address}, buffers them in a small FIFO and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module inst_loader #(
    parameter int         DEPTH     = 4,
    parameter logic [9:0] BASE_ADDR = 10'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_addr_mode,
    input  logic [4:0]  in_opcode,
    input  logic [9:0]  in_address,
    input  logic        in_last,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [9:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [10:0] count,
    output logic        done,
    output logic        err
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC  = (AW + 1)'(DEPTH);
    localparam logic [9:0]  LAST_ADDR = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [15:0]      fifo_word_q [DEPTH];
    logic [DEPTH-1:0] fifo_last_q;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   occ_q, occ_d;
    logic [9:0]    wptr_q, wptr_d;
    logic [10:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          last_seen_q, last_seen_d;
    logic [15:0]   hold_q, hold_d;

    logic        fifo_full, fifo_empty;
    logic        push, pop, flush, begin_s;
    logic        head_last;
    logic [15:0] in_word, head_word;

    assign in_word    = {in_addr_mode, in_opcode, in_address};
    assign head_word  = fifo_word_q[head_q];
    assign head_last  = fifo_last_q[head_q];
    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == FULL_OCC);

    // When the FIFO is empty the write data keeps showing the last word written.
    assign mem_addr  = wptr_q;
    assign mem_wdata = fifo_empty ? hold_q : head_word;
    assign count     = count_q;
    assign err       = err_q;

    // Next-state logic: session FSM, FIFO handshakes and write-pointer advance.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        hold_d      = hold_q;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        begin_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin_s = 1'b1;
            end
            S_LOAD: begin
                // A pop in the same cycle never frees a slot for a push when full.
                in_ready = !fifo_full && !last_seen_q;
                mem_we   = !fifo_empty;
                push     = in_valid && in_ready;
                pop      = mem_we && mem_ready;
                if (push) begin
                    tail_d = tail_q + AW'(1);
                    if (in_last) last_seen_d = 1'b1;
                end
                if (pop) begin
                    head_d  = head_q + AW'(1);
                    wptr_d  = wptr_q + 10'd1;
                    count_d = count_q + 11'd1;
                    hold_d  = head_word;
                end
                occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
                // The last word wins over overflow when both land on address 1023.
                if (pop && head_last) begin
                    state_d = S_DONE;
                end else if (pop && (wptr_q == LAST_ADDR)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin_s = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (begin_s) begin
            state_d     = S_LOAD;
            wptr_d      = BASE_ADDR;
            count_d     = '0;
            err_d       = 1'b0;
            last_seen_d = 1'b0;
            flush       = 1'b1;
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    // Control registers: FSM state, FIFO pointers, write pointer, count and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            wptr_q      <= BASE_ADDR;
            count_q     <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            hold_q      <= hold_d;
        end
    end

    // FIFO storage: captures each accepted word and its last flag; not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word_q[tail_q] <= in_word;
            fifo_last_q[tail_q] <= in_last;
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed and random stimulus for inst_loader, checked
// against a transaction-level session model (queue of pending words).
module tb_inst_loader;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_addr_mode, in_last, mem_ready;
    logic [4:0]  in_opcode;
    logic [9:0]  in_address;
    logic        in_ready, mem_we, done, err;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [10:0] count;

    logic        h_start, h_in_valid, h_am, h_last, h_mem_ready;
    logic [4:0]  h_op;
    logic [9:0]  h_ad;
    logic        h_in_ready, h_mem_we, h_done, h_err;
    logic [9:0]  h_mem_addr;
    logic [15:0] h_mem_wdata;
    logic [10:0] h_count;

    inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(10'd0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr_mode(in_addr_mode), .in_opcode(in_opcode), .in_address(in_address),
        .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .done(done), .err(err)
    );

    inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(10'd1022)) u_hi (
        .clk(clk), .rst(rst), .start(h_start), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_addr_mode(h_am), .in_opcode(h_op), .in_address(h_ad),
        .in_last(h_last), .mem_we(h_mem_we), .mem_ready(h_mem_ready), .mem_addr(h_mem_addr),
        .mem_wdata(h_mem_wdata), .count(h_count), .done(h_done), .err(h_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Session model: phase 0 idle, 1 loading, 2 done pulse, 3 overflow error.
    int          ph;
    logic [15:0] q_word[$];
    bit          q_last[$];
    int          m_addr, m_cnt;
    bit          m_err, m_last_seen;
    bit          last_acc;
    int          n_done;
    int          obs_a[$];
    int          obs_d[$];

    function automatic logic [15:0] pack(int am, int op, int ad);
        return 16'(am * 32768 + op * 1024 + ad);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        ph = 0;
        q_word.delete();
        q_last.delete();
        m_addr = 0;
        m_cnt = 0;
        m_err = 1'b0;
        m_last_seen = 1'b0;
    endtask

    task automatic begin_session();
        ph = 1;
        q_word.delete();
        q_last.delete();
        m_addr = 0;
        m_cnt = 0;
        m_err = 1'b0;
        m_last_seen = 1'b0;
    endtask

    // One clock: compare outputs with the model, clock, then advance the model.
    task automatic step();
        bit e_rdy, e_we, acc, wr, wl;
        int wa;
        e_rdy = (ph == 1) && (q_word.size() < DEPTH) && !m_last_seen;
        e_we  = (ph == 1) && (q_word.size() > 0);
        chk("in_ready", in_ready, e_rdy);
        chk("mem_we", mem_we, e_we);
        chk("done", done, ph == 2);
        chk("err", err, m_err);
        chk("count", count, m_cnt);
        if (e_we) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, q_word[0]);
        end
        if (done) n_done++;
        if (mem_we && mem_ready) begin
            obs_a.push_back(int'(mem_addr));
            obs_d.push_back(int'(mem_wdata));
        end
        acc = in_valid && e_rdy;
        wr  = e_we && mem_ready;
        last_acc = acc;
        @(posedge clk);
        if (rst) begin
            reset_model();
        end else begin
            case (ph)
                0: if (start) begin_session();
                1: begin
                    wl = 1'b0;
                    wa = m_addr;
                    if (wr) begin
                        void'(q_word.pop_front());
                        wl = q_last.pop_front();
                        m_addr = (m_addr + 1) % 1024;
                        m_cnt++;
                    end
                    if (acc) begin
                        q_word.push_back(pack(int'(in_addr_mode), int'(in_opcode), int'(in_address)));
                        q_last.push_back(in_last);
                        if (in_last) m_last_seen = 1'b1;
                    end
                    if (wr && wl) begin
                        ph = 2;
                    end else if (wr && wa == 1023) begin
                        ph = 3;
                        m_err = 1'b1;
                        q_word.delete();
                        q_last.delete();
                    end
                end
                2: ph = 0;
                3: if (start) begin_session();
                default: ph = 0;
            endcase
        end
        #1;
    endtask

    task automatic send(input bit am, input logic [4:0] op, input logic [9:0] ad,
                        input bit lst, input string tag);
        int g;
        in_valid = 1'b1; in_addr_mode = am; in_opcode = op; in_address = ad; in_last = lst;
        g = 0;
        do begin
            step();
            g++;
        end while (!last_acc && g < 50);
        chk({tag, "_accept_timeout"}, last_acc, 1'b1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int g;
        g = 0;
        while (ph != 0 && g < bound) begin
            step();
            g++;
        end
        chk({tag, "_idle_timeout"}, ph == 0, 1'b1);
    endtask

    bit          hs_am[3];
    logic [4:0]  hs_op[3];
    logic [9:0]  hs_ad[3];
    int          ha[$];
    int          hd[$];

    task automatic hset(input int k);
        if (k < 3) begin
            h_in_valid = 1'b1; h_am = hs_am[k]; h_op = hs_op[k]; h_ad = hs_ad[k];
        end else begin
            h_in_valid = 1'b0;
        end
    endtask

    initial begin
        int k, g, dut_acc;
        bit hacc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_addr_mode = 1'b0; in_opcode = '0;
        in_address = '0; in_last = 1'b0; mem_ready = 1'b1;
        h_start = 1'b0; h_in_valid = 1'b0; h_am = 1'b0; h_op = '0; h_ad = '0;
        h_last = 1'b0; h_mem_ready = 1'b1;
        n_done = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", count, 11'd0);
        chk("rst_mem_addr", mem_addr, 10'd0);
        chk("rst_mem_wdata", mem_wdata, 16'd0);
        chk("rst_hi_mem_addr", h_mem_addr, 10'd1022);
        rst = 1'b0;

        // Overflow near the top of the address space on the high-base instance.
        hs_am[0] = 1'b1; hs_op[0] = 5'h02; hs_ad[0] = 10'h111;
        hs_am[1] = 1'b0; hs_op[1] = 5'h10; hs_ad[1] = 10'h2AA;
        hs_am[2] = 1'b1; hs_op[2] = 5'h00; hs_ad[2] = 10'h001;
        h_start = 1'b1;
        @(posedge clk); #1;
        h_start = 1'b0;
        k = 0;
        hset(k);
        for (int c = 0; c < 12; c++) begin
            if (h_mem_we && h_mem_ready) begin
                ha.push_back(int'(h_mem_addr));
                hd.push_back(int'(h_mem_wdata));
            end
            hacc = h_in_valid && h_in_ready;
            @(posedge clk); #1;
            if (hacc) begin
                k++;
                hset(k);
            end
        end
        chk("hi_write_count", ha.size(), 2);
        chk("hi_addr0", ha[0], 1022);
        chk("hi_addr1", ha[1], 1023);
        chk("hi_data0", hd[0], pack(1, 2, 'h111));
        chk("hi_data1", hd[1], pack(0, 16, 'h2AA));
        chk("hi_err", h_err, 1'b1);
        chk("hi_in_ready", h_in_ready, 1'b0);
        chk("hi_mem_we", h_mem_we, 1'b0);
        chk("hi_count", h_count, 11'd2);

        // Three-word session with a stray start while loading and stray valids after.
        obs_a.delete(); obs_d.delete(); n_done = 0;
        start = 1'b1; step(); start = 1'b0;
        send(1'b0, 5'h03, 10'h00A, 1'b0, "t1_s0");
        send(1'b1, 5'h1F, 10'h3FF, 1'b0, "t1_s1");
        send(1'b0, 5'h00, 10'h000, 1'b1, "t1_s2");
        in_valid = 1'b1; start = 1'b1; step(); start = 1'b0;
        run_until_idle(20, "t1");
        repeat (4) step();
        in_valid = 1'b0;
        chk("t1_nwrites", obs_a.size(), 3);
        chk("t1_a0", obs_a[0], 0);
        chk("t1_d0", obs_d[0], 16'h0C0A);
        chk("t1_a1", obs_a[1], 1);
        chk("t1_d1", obs_d[1], 16'hFFFF);
        chk("t1_a2", obs_a[2], 2);
        chk("t1_d2", obs_d[2], 16'h0000);
        chk("t1_count", count, 11'd3);
        chk("t1_done_pulses", n_done, 1);

        // Backpressure: memory stalled with a continuous input stream.
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b0; in_valid = 1'b1; dut_acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_addr_mode = 1'($urandom); in_opcode = 5'($urandom); in_address = 10'($urandom);
            if (in_valid && in_ready) dut_acc++;
            step();
        end
        chk("t2_accepts", dut_acc, DEPTH);
        mem_ready = 1'b1;
        send(1'b1, 5'h15, 10'h155, 1'b1, "t2_last");
        run_until_idle(30, "t2");

        // Reset in the middle of a session with words buffered.
        start = 1'b1; step(); start = 1'b0;
        mem_ready = 1'b0;
        send(1'b0, 5'h01, 10'h001, 1'b0, "t4_s0");
        send(1'b0, 5'h02, 10'h002, 1'b0, "t4_s1");
        rst = 1'b1; step(); rst = 1'b0;
        chk("t4_mem_we", mem_we, 1'b0);
        chk("t4_in_ready", in_ready, 1'b0);
        chk("t4_count", count, 11'd0);
        mem_ready = 1'b1;
        repeat (3) step();

        // Single-word session.
        obs_a.delete(); obs_d.delete(); n_done = 0;
        start = 1'b1; step(); start = 1'b0;
        send(1'b1, 5'h0A, 10'h2C3, 1'b1, "t6");
        run_until_idle(10, "t6");
        chk("t6_nwrites", obs_a.size(), 1);
        chk("t6_addr", obs_a[0], 0);
        chk("t6_data", obs_d[0], pack(1, 10, 'h2C3));
        chk("t6_done_pulses", n_done, 1);

        // Full address space without a last word: overflow into error.
        obs_a.delete(); obs_d.delete();
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_last = 1'b0; mem_ready = 1'b1;
        g = 0;
        while (ph != 3 && g < 1200) begin
            in_addr_mode = 1'($urandom); in_opcode = 5'($urandom); in_address = 10'($urandom);
            step();
            g++;
        end
        chk("ovf_reached", ph == 3, 1'b1);
        repeat (3) step();
        in_valid = 1'b0;
        chk("ovf_nwrites", obs_a.size(), 1024);
        chk("ovf_last_addr", obs_a[obs_a.size() - 1], 1023);
        chk("ovf_err", err, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        chk("ovf_err_cleared", err, 1'b0);

        // Random traffic with occasional starts and resets.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_addr_mode = 1'($urandom); in_opcode = 5'($urandom); in_address = 10'($urandom);
            in_last = ($urandom_range(0, 9) == 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
